port_out_arbiter: RTL and testbench

PORT_OUT_ARBITER -- requirements
Module: port_out_arbiter

---
 rtl/port_out_arbiter.sv | 133 +++++++++++++
 tb/tb_port_out_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/port_out_arbiter.sv
// rtl/port_out_arbiter.sv - two-requester output-port write arbiter (IDLE->WRITE->ACK)
// Define PORT_ARB_RR_EN for round-robin tie-breaking; default build is fixed priority (A wins).
module port_out_arbiter #(
    parameter logic [7:0] BASE_ADDR = 8'hE0,
    parameter int         PORT_CNT  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_a,
    input  logic       req_b,
    input  logic [7:0] addr_a,
    input  logic [7:0] addr_b,
    input  logic [7:0] data_a,
    input  logic [7:0] data_b,
    output logic       ack_a,
    output logic       ack_b,
    output logic       err_a,
    output logic       err_b,
    output logic [7:0] address,
    output logic [7:0] data_out,
    output logic       write,
    output logic       busy,
    output logic [7:0] write_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_ACK   = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       r_win_b;
    logic [7:0] r_addr;
    logic [7:0] r_data;
    logic [7:0] r_write_count;
    logic       w_grant_b;
    logic       w_start;
    logic       w_in_range;
    logic [8:0] w_lo;
    logic [8:0] w_hi;

    assign w_start = (r_state == S_IDLE) && (req_a || req_b);

`ifdef PORT_ARB_RR_EN
    logic r_last_b;

    // On a tie the requester that was not served last wins.
    assign w_grant_b = req_b && (!req_a || !r_last_b);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_b <= 1'b1;
        end else if (w_start) begin
            r_last_b <= w_grant_b;
        end
    end
`else
    assign w_grant_b = req_b && !req_a;
`endif

    // Nine-bit compare so BASE_ADDR+PORT_CNT can reach 9'h100 without wrapping.
    assign w_lo       = {1'b0, BASE_ADDR};
    assign w_hi       = w_lo + 9'(PORT_CNT);
    assign w_in_range = ({1'b0, r_addr} >= w_lo) && ({1'b0, r_addr} < w_hi);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_win_b <= 1'b0;
            r_addr  <= 8'h00;
            r_data  <= 8'h00;
        end else if (w_start) begin
            r_win_b <= w_grant_b;
            r_addr  <= w_grant_b ? addr_b : addr_a;
            r_data  <= w_grant_b ? data_b : data_a;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_write_count <= 8'h00;
        end else if ((r_state == S_WRITE) && w_in_range) begin
            r_write_count <= r_write_count + 8'h01;
        end
    end

    assign write_count = r_write_count;

    always_comb begin
        w_next   = r_state;
        ack_a    = 1'b0;
        ack_b    = 1'b0;
        err_a    = 1'b0;
        err_b    = 1'b0;
        address  = 8'h00;
        data_out = 8'h00;
        write    = 1'b0;
        busy     = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (req_a || req_b) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                address  = r_addr;
                data_out = r_data;
                write    = w_in_range;
                w_next   = S_ACK;
            end
            S_ACK: begin
                ack_a  = !r_win_b;
                ack_b  = r_win_b;
                err_a  = !r_win_b && !w_in_range;
                err_b  = r_win_b && !w_in_range;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_port_out_arbiter.sv
// tb/tb_port_out_arbiter.sv - scoreboard bench for port_out_arbiter
// Honours PORT_ARB_RR_EN in its arbitration model when the macro is defined.
module tb_port_out_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_a, req_b;
    logic [7:0] addr_a, addr_b, data_a, data_b;
    logic       ack_a, ack_b, err_a, err_b;
    logic [7:0] address, data_out, write_count;
    logic       write, busy;

    port_out_arbiter dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .req_b(req_b),
        .addr_a(addr_a), .addr_b(addr_b),
        .data_a(data_a), .data_b(data_b),
        .ack_a(ack_a), .ack_b(ack_b),
        .err_a(err_a), .err_b(err_b),
        .address(address), .data_out(data_out),
        .write(write), .busy(busy),
        .write_count(write_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         win_b;
        logic [7:0] addr;
        logic [7:0] data;
        bit         wr;
    } exp_t;

    exp_t       sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    bit         m_last_b;
    logic [7:0] m_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit in_range(input logic [7:0] a);
        return (int'(a) >= 224) && (int'(a) < 240);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_write"}, write, 0);
        check({tag, "_ack"}, {ack_a, ack_b, err_a, err_b}, 0);
        check({tag, "_addr"}, address, 0);
        check({tag, "_data"}, data_out, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_count"}, write_count, 0);
    endtask

    // Called just after a rising edge with the DUT idle; returns 3 cycles later.
    task automatic txn(input bit ra, input logic [7:0] aa, input logic [7:0] da,
                       input bit rb, input logic [7:0] ab, input logic [7:0] db,
                       input bit keep, input bit mid);
        exp_t e;
        req_a = ra; addr_a = aa; data_a = da;
        req_b = rb; addr_b = ab; data_b = db;
        if (ra && rb) begin
`ifdef PORT_ARB_RR_EN
            e.win_b = !m_last_b;
`else
            e.win_b = 1'b0;
`endif
        end else begin
            e.win_b = rb;
        end
        m_last_b = e.win_b;
        e.addr   = e.win_b ? ab : aa;
        e.data   = e.win_b ? db : da;
        e.wr     = in_range(e.addr);
        sb.push_back(e);

        @(posedge clk); #1;
        if (mid) begin
            req_a = 1'b0; req_b = 1'b0;
            addr_a = ~aa; addr_b = ~ab; data_a = ~da; data_b = ~db;
        end
        #1;
        e = sb[0];
        check("wr_write", write, e.wr);
        check("wr_address", address, e.addr);
        check("wr_data_out", data_out, e.data);
        check("wr_busy", busy, 1);
        check("wr_no_ack", {ack_a, ack_b}, 0);
        if (e.wr) m_count = m_count + 8'h01;

        @(posedge clk); #1;
        e = sb.pop_front();
        check("ack_a", ack_a, !e.win_b);
        check("ack_b", ack_b, e.win_b);
        check("err_a", err_a, !e.win_b && !e.wr);
        check("err_b", err_b, e.win_b && !e.wr);
        check("ack_write", write, 0);
        check("ack_address", {address, data_out}, 0);
        check("ack_busy", busy, 1);
        check("write_count", write_count, m_count);
        if (!keep) begin
            req_a = 1'b0; req_b = 1'b0;
        end

        @(posedge clk); #1;
        check("idle_busy", busy, 0);
        check("idle_ack", {ack_a, ack_b, err_a, err_b}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        req_a = 1'b0; req_b = 1'b0;
        addr_a = 8'h00; addr_b = 8'h00; data_a = 8'h00; data_b = 8'h00;
        m_last_b = 1'b1;
        m_count  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("rst");
        reset = 1'b0;

        txn(1, 8'hE3, 8'h5A, 0, 8'h00, 8'h00, 0, 0);
        check("first_count", write_count, 8'h01);
        txn(0, 8'h00, 8'h00, 1, 8'hF0, 8'h77, 0, 0);

        for (int i = 0; i < 4; i++) begin
            txn(1, 8'hE1, 8'(i), 1, 8'hE2, 8'(i + 16), (i != 3), 0);
        end

        txn(1, 8'hE4, 8'h33, 0, 8'h00, 8'h00, 0, 1);
        txn(0, 8'h00, 8'h00, 1, 8'hE9, 8'h44, 0, 1);

        txn(1, 8'hEF, 8'h11, 0, 8'h00, 8'h00, 0, 0);
        txn(1, 8'hDF, 8'h22, 0, 8'h00, 8'h00, 0, 0);
        txn(0, 8'h00, 8'h00, 1, 8'hE0, 8'h66, 0, 0);
        txn(1, 8'hF0, 8'h55, 0, 8'h00, 8'h00, 0, 0);
        txn(0, 8'h00, 8'h00, 1, 8'hFF, 8'h99, 0, 0);

        // Reset in the WRITE cycle: discard, then the held request is sampled on the first edge.
        req_a = 1'b1; addr_a = 8'hE5; data_a = 8'hC3;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check_all_zero("midrst");
        @(posedge clk); #1;
        check_all_zero("midrst_hold");
        reset    = 1'b0;
        m_count  = 8'h00;
        m_last_b = 1'b1;
        txn(1, 8'hE5, 8'hC3, 0, 8'h00, 8'h00, 0, 0);

        for (int i = 0; i < 255; i++) begin
            txn(1, 8'hE0 + 8'(i % 16), 8'(i), 0, 8'h00, 8'h00, 0, 0);
        end
        check("count_wrap", write_count, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
